ex_operand_stage: RTL
=====================

# ex_operand_stage

Execute-stage operand register feeding the ALU/shift datapath of the RV32I core. Accepts decoded instructions from the decode stage over a valid/ready handshake and resolves rs1/rs2 through MEM and WB forwarding. Selects the immediate or register for operand B, then holds the result in a two-entry skid buffer. Its registered outputs drive the combinational ALU and shift unit directly (operand_a, operand_b, shift select).

## Interface
- XLEN, 32, datapath width
- RF_AW, 5, register-file address width
- OP_W, 4, width of the ALU opcode field
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage can accept (registered)
- in_rs1_addr, in_rs2_addr  in  RF_AW  source register indices
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data
- in_imm  in  XLEN  sign-extended immediate
- in_use_imm  in  1  operand_b takes in_imm instead of rs2
- in_shift_sel  in  2  00=SLL, 01=SRL, 10=SRA
- in_alu_op  in  OP_W  ALU function code, passed through
- in_rd_addr  in  RF_AW  destination index
- in_rd_we  in  1  destination write enable
- flush  in  1  kill all held and incoming instructions
- mem_fwd_we, wb_fwd_we  in  1  producer in MEM/WB writes a register
- mem_fwd_addr, wb_fwd_addr  in  RF_AW  producer destination
- mem_fwd_data, wb_fwd_data  in  XLEN  producer result
- out_valid  out  1  operands for the head instruction are valid
- out_ready  in  1  execute consumes head this cycle
- operand_a, operand_b  out  XLEN  ALU/shift operands
- shift_sel  out  2  to shift unit sel
- alu_op  out  OP_W  to ALU
- rd_addr  out  RF_AW; rd_we  out  1  destination, passed through

## Operation
- Forwarding is applied to each source at capture time only:
  - MEM match (mem_fwd_we && addr==src && src!=0) takes priority.
  - Otherwise WB match, under the same rule.
  - Otherwise register-file data.
  - Source x0 always yields 0.
- operand_b is in_imm when in_use_imm=1; otherwise the forwarded rs2 value. The full 32 bits are passed; the shift unit uses bits [4:0].
- Storage consists of a head entry and a skid entry. The state machine has three states:
  - EMPTY: in_ready=1, out_valid=0. An accept moves to HEAD.
  - HEAD: in_ready=1, out_valid=1.
    - Accept without consume: go to FULL.
    - Consume without accept: go to EMPTY.
    - Both: new entry replaces head, stay in HEAD.
  - FULL: in_ready=0, out_valid=1. A consume moves the skid entry into head and goes to HEAD.
- Accept = in_valid && in_ready. Consume = out_valid && out_ready.
- Entries are never reordered; the skid entry is always younger than the head.
- flush has priority over everything:
  - Next state is EMPTY.
  - Same-cycle in_valid is dropped.
  - rd_we of both entries is cleared.
  - Data fields may retain their values.

## Timing
- Reset values: state EMPTY, in_ready=1, out_valid=0; operand_a, operand_b, alu_op, rd_addr, shift_sel all 0; rd_we=0.
- Latency: an instruction accepted in cycle N is visible at the outputs with out_valid=1 in cycle N+1.
- Throughput is one instruction per cycle while out_ready=1.
- in_ready is a flop output. It depends only on state, never combinationally on out_ready.
- Outputs are stable while out_valid=1 and out_ready=0.
- Forwarding inputs are sampled in the accept cycle only. Later changes do not affect stored entries.
- Reset asserted mid-operation: both entries are discarded immediately. Outputs return to reset values asynchronously.
- flush and out_ready in the same cycle: the head is considered not consumed by downstream and is squashed.

## Structure
- Package rv32i_pkg holds:
  - XLEN and RF_AW constants.
  - shift_sel_e (SLL=2'b00, SRL=2'b01, SRA=2'b10).
  - alu_op_e.
  - A packed struct ex_entry_t (op_a, op_b, shift_sel, alu_op, rd_addr, rd_we) used for both entries.
- Sub-module operand_fwd_mux is purely combinational. Its ports are src_addr, rf_data and both forward ports; its output is the resolved value. It is instantiated twice, for rs1 and rs2.
- State register uses a 2-bit enum: EMPTY, HEAD, FULL.

## Test plan
- Reset, then accept rs1 data=0x0000_00F0, rs2 data=0x4, in_use_imm=0, shift_sel=SLL -> next cycle out_valid=1, operand_a=0xF0, operand_b=0x4, shift_sel=00.
- rs1_addr=5 with mem_fwd {we=1, addr=5, data=0x8000_0000}, wb_fwd {we=1, addr=5, data=0x1} -> operand_a=0x8000_0000 (MEM wins). Repeat with rs1_addr=0 -> operand_a=0.
- Backpressure: out_ready=0, send A then B.
  - Required: in_ready falls to 0 after B.
  - A is held unchanged.
  - Releasing out_ready yields A, then B on consecutive cycles with no loss.
- Streaming 8 instructions with out_ready=1 throughout -> in_ready stays 1, and 8 consecutive out_valid beats appear in order.
- FULL state, then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and no flushed instruction ever appears.
- in_use_imm=1, in_imm=0xFFFF_FFE3, rs2 forwarding match present -> operand_b=0xFFFF_FFE3 (immediate not overridden).

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I execute-stage types: widths, shift/ALU encodings, held-entry layout.
package rv32i_pkg;
    localparam int XLEN  = 32;
    localparam int RF_AW = 5;
    localparam int OP_W  = 4;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10
    } shift_sel_e;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_SLT  = 4'h2,
        ALU_SLTU = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_OR   = 4'h5,
        ALU_AND  = 4'h6,
        ALU_SHF  = 4'h7,
        ALU_LUI  = 4'h8
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HEAD  = 2'b01,
        ST_FULL  = 2'b10
    } stage_state_e;

    typedef struct packed {
        logic [XLEN-1:0]  op_a;
        logic [XLEN-1:0]  op_b;
        shift_sel_e       shift_sel;
        alu_op_e          alu_op;
        logic [RF_AW-1:0] rd_addr;
        logic             rd_we;
    } ex_entry_t;
endpackage

// File: rtl/operand_fwd_mux.sv
// Resolves one source operand: MEM result, then WB result, then register file; x0 reads 0.
// Purely combinational, no handshake.
module operand_fwd_mux
    import rv32i_pkg::*;
(
    input  logic [RF_AW-1:0] src_addr,
    input  logic [XLEN-1:0]  rf_data,
    input  logic             mem_fwd_we,
    input  logic [RF_AW-1:0] mem_fwd_addr,
    input  logic [XLEN-1:0]  mem_fwd_data,
    input  logic             wb_fwd_we,
    input  logic [RF_AW-1:0] wb_fwd_addr,
    input  logic [XLEN-1:0]  wb_fwd_data,
    output logic [XLEN-1:0]  fwd_data
);
    logic src_nz;

    assign src_nz = (src_addr != '0);

    always_comb begin
        fwd_data = rf_data;
        if (!src_nz)
            fwd_data = '0;
        else if (mem_fwd_we && (mem_fwd_addr == src_addr))
            fwd_data = mem_fwd_data;
        else if (wb_fwd_we && (wb_fwd_addr == src_addr))
            fwd_data = wb_fwd_data;
    end
endmodule

// File: rtl/ex_operand_stage.sv
// Execute operand register: forwards rs1/rs2 at capture, picks imm/rs2, holds head + skid entry.
// One cycle accept-to-output; in_ready is a registered function of occupancy only.
module ex_operand_stage
    import rv32i_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RF_AW-1:0] in_rs1_addr,
    input  logic [RF_AW-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_use_imm,
    input  logic [1:0]       in_shift_sel,
    input  logic [OP_W-1:0]  in_alu_op,
    input  logic [RF_AW-1:0] in_rd_addr,
    input  logic             in_rd_we,
    input  logic             flush,
    input  logic             mem_fwd_we,
    input  logic [RF_AW-1:0] mem_fwd_addr,
    input  logic [XLEN-1:0]  mem_fwd_data,
    input  logic             wb_fwd_we,
    input  logic [RF_AW-1:0] wb_fwd_addr,
    input  logic [XLEN-1:0]  wb_fwd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  operand_a,
    output logic [XLEN-1:0]  operand_b,
    output logic [1:0]       shift_sel,
    output logic [OP_W-1:0]  alu_op,
    output logic [RF_AW-1:0] rd_addr,
    output logic             rd_we
);
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    ex_entry_t       in_entry;
    ex_entry_t       head_q;
    ex_entry_t       skid_q;
    stage_state_e    state_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            accept;
    logic            consume;

    operand_fwd_mux u_fwd_rs1 (
        .src_addr     (in_rs1_addr),
        .rf_data      (in_rs1_data),
        .mem_fwd_we   (mem_fwd_we),
        .mem_fwd_addr (mem_fwd_addr),
        .mem_fwd_data (mem_fwd_data),
        .wb_fwd_we    (wb_fwd_we),
        .wb_fwd_addr  (wb_fwd_addr),
        .wb_fwd_data  (wb_fwd_data),
        .fwd_data     (rs1_fwd)
    );

    operand_fwd_mux u_fwd_rs2 (
        .src_addr     (in_rs2_addr),
        .rf_data      (in_rs2_data),
        .mem_fwd_we   (mem_fwd_we),
        .mem_fwd_addr (mem_fwd_addr),
        .mem_fwd_data (mem_fwd_data),
        .wb_fwd_we    (wb_fwd_we),
        .wb_fwd_addr  (wb_fwd_addr),
        .wb_fwd_data  (wb_fwd_data),
        .fwd_data     (rs2_fwd)
    );

    always_comb begin
        in_entry           = '0;
        in_entry.op_a      = rs1_fwd;
        in_entry.op_b      = in_use_imm ? in_imm : rs2_fwd;
        in_entry.shift_sel = shift_sel_e'(in_shift_sel);
        in_entry.alu_op    = alu_op_e'(in_alu_op);
        in_entry.rd_addr   = in_rd_addr;
        in_entry.rd_we     = in_rd_we;
    end

    assign accept  = in_valid && in_ready_q;
    assign consume = out_valid_q && out_ready;

    // Flush wins over any same-cycle accept or consume; only write enables need killing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_q      <= '0;
            skid_q      <= '0;
        end else if (flush) begin
            state_q      <= ST_EMPTY;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            head_q.rd_we <= 1'b0;
            skid_q.rd_we <= 1'b0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        head_q      <= in_entry;
                        state_q     <= ST_HEAD;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_HEAD: begin
                    if (accept && !consume) begin
                        skid_q     <= in_entry;
                        state_q    <= ST_FULL;
                        in_ready_q <= 1'b0;
                    end else if (consume && !accept) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                    end else if (accept && consume) begin
                        head_q <= in_entry;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        head_q     <= skid_q;
                        state_q    <= ST_HEAD;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign operand_a = head_q.op_a;
    assign operand_b = head_q.op_b;
    assign shift_sel = head_q.shift_sel;
    assign alu_op    = head_q.alu_op;
    assign rd_addr   = head_q.rd_addr;
    assign rd_we     = head_q.rd_we;
endmodule
